// File: rtl/countdown_stop_if.sv
// Bus for countdown_stop: load/start/pause controls in, count and status out.
interface countdown_stop_if #(
    parameter int DATA_WIDTH = 10
) ();
    logic                  load;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  start;
    logic                  pause;
    logic [DATA_WIDTH-1:0] out;
    logic                  busy;
    logic                  done;
    logic                  expired;

    modport master (
        output load, load_val, start, pause,
        input  out, busy, done, expired
    );

    modport slave (
        input  load, load_val, start, pause,
        output out, busy, done, expired
    );
endinterface

// File: rtl/countdown_stop.sv
// Loadable down-counter that stops at MIN_VAL, with pause/resume and restart from
// a reload register. All outputs are registered.
module countdown_stop #(
    parameter int DATA_WIDTH = 10,
    parameter int MIN_VAL    = 0
) (
    input logic             clk,
    input logic             rst,
    countdown_stop_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam logic [DATA_WIDTH-1:0] MIN    = DATA_WIDTH'(MIN_VAL);
    localparam logic [DATA_WIDTH-1:0] ONE    = DATA_WIDTH'(1);
    // One bit wider so MIN_VAL at the top of the range cannot wrap.
    localparam logic [DATA_WIDTH:0]   MIN_P1 = {1'b0, MIN} + {{DATA_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  expired_q, expired_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            out_q     <= '0;
            reload_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            reload_q  <= reload_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (bus.load) begin
            out_d    = bus.load_val;
            reload_d = bus.load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (out_q > MIN) begin
                            state_d = RUN;
                        end else begin
                            state_d = EXPIRED;
                            done_d  = ~done_q;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if ({1'b0, out_q} <= MIN_P1) begin
                        out_d   = MIN;
                        state_d = EXPIRED;
                        done_d  = 1'b1;
                    end else begin
                        out_d = out_q - ONE;
                    end
                end
                PAUSED: begin
                    if (bus.start) state_d = RUN;
                end
                EXPIRED: begin
                    // A zero-length restart re-expires; suppressing back-to-back done keeps it a pulse.
                    if (bus.start) begin
                        if (reload_q > MIN) begin
                            out_d   = reload_q;
                            state_d = RUN;
                        end else begin
                            done_d = ~done_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d    = (state_d == RUN) || (state_d == PAUSED);
        expired_d = (state_d == EXPIRED);
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;
endmodule

// File: tb/tb_countdown_stop.sv
// Randomized and directed bench for countdown_stop against a behavioural model.
module tb_countdown_stop;
    localparam int DW   = 10;
    localparam int MINV = 0;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    countdown_stop_if #(.DATA_WIDTH(DW)) bus ();

    countdown_stop #(.DATA_WIDTH(DW), .MIN_VAL(MINV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;
    bit prev_done   = 1'b0;

    int m_out  = 0;
    int m_rel  = 0;
    int m_mode = M_IDLE;
    bit m_done = 1'b0;
    bit m_was;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts in plain integers, so "below MIN" is visible as such.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out = 0; m_rel = 0; m_mode = M_IDLE; m_done = 1'b0;
        end else begin
            m_was  = m_done;
            m_done = 1'b0;
            if (bus.load) begin
                m_out  = int'(bus.load_val);
                m_rel  = m_out;
                m_mode = M_IDLE;
            end else if (m_mode == M_RUN) begin
                if (bus.pause) m_mode = M_PAUSE;
                else if (m_out - 1 <= MINV) begin
                    m_out = MINV; m_mode = M_EXP; m_done = 1'b1;
                end else m_out = m_out - 1;
            end else if (m_mode == M_IDLE) begin
                if (bus.start) begin
                    if (m_out > MINV) m_mode = M_RUN;
                    else begin m_mode = M_EXP; m_done = !m_was; end
                end
            end else if (m_mode == M_PAUSE) begin
                if (bus.start) m_mode = M_RUN;
            end else begin
                if (bus.start) begin
                    if (m_rel > MINV) begin m_out = m_rel; m_mode = M_RUN; end
                    else m_done = !m_was;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out", int'(bus.out), m_out);
            chk("busy", int'(bus.busy), int'(m_mode == M_RUN || m_mode == M_PAUSE));
            chk("done", int'(bus.done), int'(m_done));
            chk("expired", int'(bus.expired), int'(m_mode == M_EXP));
            chk("done_back_to_back", int'(bus.done & prev_done), 0);
            prev_done = bus.done;
        end
    end

    task automatic step(input bit l, input int lv, input bit s, input bit p);
        @(negedge clk);
        bus.load     = l;
        bus.load_val = DW'(lv);
        bus.start    = s;
        bus.pause    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input int o, input int b, input int d, input int e);
        chk({name, ".out"}, int'(bus.out), o);
        chk({name, ".busy"}, int'(bus.busy), b);
        chk({name, ".done"}, int'(bus.done), d);
        chk({name, ".expired"}, int'(bus.expired), e);
    endtask

    int dcount;

    initial begin
        bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0; bus.pause = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst    = 1'b1;
        cmp_en = 1'b1;

        // Load 5 and run to expiry, then hold
        step(1, 5, 0, 0);  chk_all("ld5", 5, 0, 0, 0);
        step(0, 0, 1, 0);  chk_all("st5", 5, 1, 0, 0);
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 0, 0);
            chk_all("run5", i, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0, (i == 0) ? 1 : 0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            chk_all("hold0", 0, 0, 0, 1);
        end

        // Load 8, pause at 6 for 4 cycles, resume
        step(1, 8, 0, 0);
        step(0, 0, 1, 0);  chk_all("st8", 8, 1, 0, 0);
        step(0, 0, 0, 0);  step(0, 0, 0, 0);  chk_all("at6", 6, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk_all("paused", 6, 1, 0, 0);
        end
        step(0, 0, 1, 0);  chk_all("resume", 6, 1, 0, 0);
        dcount = 0;
        for (int i = 5; i >= 0; i--) begin
            step(0, 0, 0, 0);
            chk("resume.out", int'(bus.out), i);
            dcount += int'(bus.done);
        end
        step(0, 0, 0, 0);
        dcount += int'(bus.done);
        chk("resume.done_pulses", dcount, 1);

        // From EXPIRED: load 3, start, second expiry
        step(1, 3, 0, 0);
        step(0, 0, 1, 0);  chk_all("re3", 3, 1, 0, 0);
        step(0, 0, 0, 0);  chk_all("re2", 2, 1, 0, 0);
        step(0, 0, 0, 0);  chk_all("re1", 1, 1, 0, 0);
        step(0, 0, 0, 0);  chk_all("re0", 0, 0, 1, 1);

        // Same-cycle priority in RUN
        step(1, 20, 0, 0);
        step(0, 0, 1, 0);
        step(1, 7, 1, 1);  chk_all("prio_load", 7, 0, 0, 0);
        step(0, 0, 1, 0);  chk_all("prio_run", 7, 1, 0, 0);
        step(0, 0, 1, 1);  chk_all("prio_pause", 7, 1, 0, 0);
        step(0, 0, 0, 0);  chk_all("prio_hold", 7, 1, 0, 0);

        // Load 0: immediate expiry, repeated start pulses again
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);  chk_all("z_start", 0, 0, 1, 1);
        step(0, 0, 0, 0);  chk_all("z_gap", 0, 0, 0, 1);
        step(0, 0, 1, 0);  chk_all("z_restart", 0, 0, 1, 1);
        step(0, 0, 0, 0);  chk_all("z_after", 0, 0, 0, 1);

        // Asynchronous reset mid-count at 500
        step(1, 600, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 0);
        chk_all("at500", 500, 1, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 1, 0);  chk_all("rst_start", 0, 0, 1, 1);

        // Full-range countdown without wrap
        step(1, 1023, 0, 0);
        step(0, 0, 1, 0);  chk_all("st1023", 1023, 1, 0, 0);
        dcount = 0;
        for (int i = 1022; i >= 0; i--) begin
            step(0, 0, 0, 0);
            dcount += int'(bus.done);
        end
        chk_all("end1023", 0, 0, 1, 1);
        step(0, 0, 0, 0);  chk_all("post1023", 0, 0, 0, 1);
        chk("full.done_pulses", dcount, 1);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                @(negedge clk);
                bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                step(($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                                 : int'($urandom_range(0, 12)),
                     ($urandom_range(0, 9) < 3),
                     ($urandom_range(0, 9) < 2));
            end
        end

        step(0, 0, 0, 0);
        @(negedge clk);
        #1 cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
